// File: rtl/reg_write_arbiter.sv
// Round-robin write arbiter driving en/data/clear of a shared N-bit register.
// Optional per-owner burst hold limit enabled by defining ARB_HOLD_LIMIT_EN.
module reg_write_arbiter #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned NREQ     = 4,
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ-1:0]          lock,
  input  logic [NREQ*WIDTH-1:0]    wdata,
  input  logic                     clr_req,
  output logic [NREQ-1:0]          gnt,
  output logic                     reg_en,
  output logic [WIDTH-1:0]         reg_d,
  output logic                     reg_clr,
  output logic                     busy,
  output logic [$clog2(NREQ)-1:0]  last_id
);

  localparam int unsigned IDW = $clog2(NREQ);

  typedef enum logic {
    S_IDLE,
    S_LOCKED
  } state_e;

  state_e           state_q, state_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [IDW-1:0]   last_id_q, last_id_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic             reg_en_q, reg_en_d;
  logic [WIDTH-1:0] reg_d_q, reg_d_d;
  logic             reg_clr_q, reg_clr_d;

  logic [WIDTH-1:0] wdata_a [NREQ];
  logic [NREQ-1:0]  arb_req;
  logic             do_arb;
  logic             found;
  logic [IDW-1:0]   pick;
  int unsigned      idx;
  logic             limit_hit;

`ifdef ARB_HOLD_LIMIT_EN
  localparam int unsigned HCW = $clog2(MAX_HOLD + 1);
  logic [HCW-1:0] hold_q, hold_d;

  assign limit_hit = (hold_q >= HCW'(MAX_HOLD));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) hold_q <= '0;
    else        hold_q <= hold_d;
  end
`else
  localparam int unsigned unused_max_hold = MAX_HOLD;
  assign limit_hit = 1'b0;
`endif

  always_comb begin
    for (int unsigned i = 0; i < NREQ; i++) begin
      wdata_a[i] = wdata[i*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    last_id_d = last_id_q;
    gnt_d     = '0;
    reg_en_d  = 1'b0;
    reg_d_d   = reg_d_q;
    reg_clr_d = 1'b0;
    arb_req   = req;
    do_arb    = 1'b0;
    found     = 1'b0;
    pick      = '0;
    idx       = 0;
`ifdef ARB_HOLD_LIMIT_EN
    hold_d    = hold_q;
`endif

    // In LOCKED, last_id_q is the owner; the pointer already sits past it.
    if (clr_req) begin
      reg_clr_d = 1'b1;
      state_d   = S_IDLE;
    end else if (state_q == S_IDLE) begin
      do_arb = 1'b1;
    end else if (limit_hit) begin
      arb_req[last_id_q] = 1'b0;
      state_d            = S_IDLE;
      do_arb             = 1'b1;
    end else if (req[last_id_q] && lock[last_id_q]) begin
      gnt_d[last_id_q] = 1'b1;
      reg_en_d         = 1'b1;
      reg_d_d          = wdata_a[last_id_q];
`ifdef ARB_HOLD_LIMIT_EN
      hold_d           = hold_q + 1'b1;
`endif
    end else begin
      state_d = S_IDLE;
      do_arb  = 1'b1;
    end

    if (do_arb) begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        idx = (32'(ptr_q) + i) % NREQ;
        if (!found && arb_req[IDW'(idx)]) begin
          found = 1'b1;
          pick  = IDW'(idx);
        end
      end
      if (found) begin
        gnt_d[pick] = 1'b1;
        reg_en_d    = 1'b1;
        reg_d_d     = wdata_a[pick];
        last_id_d   = pick;
        ptr_d       = (pick == IDW'(NREQ - 1)) ? '0 : pick + 1'b1;
        if (lock[pick]) begin
          state_d = S_LOCKED;
`ifdef ARB_HOLD_LIMIT_EN
          hold_d  = HCW'(1);
`endif
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      ptr_q     <= '0;
      last_id_q <= '0;
      gnt_q     <= '0;
      reg_en_q  <= 1'b0;
      reg_d_q   <= '0;
      reg_clr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      last_id_q <= last_id_d;
      gnt_q     <= gnt_d;
      reg_en_q  <= reg_en_d;
      reg_d_q   <= reg_d_d;
      reg_clr_q <= reg_clr_d;
    end
  end

  assign gnt     = gnt_q;
  assign reg_en  = reg_en_q;
  assign reg_d   = reg_d_q;
  assign reg_clr = reg_clr_q;
  assign busy    = (state_q == S_LOCKED);
  assign last_id = last_id_q;

endmodule
